// File: rtl/sdrc_app_responder.sv
// Behavioural stand-in for the sdrc_core application port: accepts burst requests,
// stores write beats in an internal word RAM and returns read bursts after RD_LAT.
module sdrc_app_responder #(
  parameter int APP_AW  = 30,
  parameter int APP_DW  = 32,
  parameter int MEM_AW  = 10,
  parameter int ACK_DLY = 2,
  parameter int RD_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                app_req,
  input  logic [APP_AW-1:0]   app_req_addr,
  input  logic [8:0]          app_req_len,
  input  logic                app_req_wr_n,
  output logic                app_req_ack,
  output logic                app_busy_n,
  input  logic [APP_DW-1:0]   app_wr_data,
  input  logic [APP_DW/8-1:0] app_wr_en_n,
  output logic                app_wr_next_req,
  output logic                app_rd_valid,
  output logic [APP_DW-1:0]   app_rd_data,
  output logic                app_last_rd,
  output logic                proto_err,
  output logic [2:0]          dbg_state
);

  // Handshake: app_req is held until the one-cycle app_req_ack; write data is
  // consumed on every edge where app_wr_next_req is high; read data is valid
  // whenever app_rd_valid is high, with no back-pressure on either side.
  localparam int NB      = APP_DW / 8;
  localparam int ACK_TGT = (ACK_DLY >= 2) ? ACK_DLY - 2 : 0;
  localparam int RD_TGT  = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_WAIT, S_ACK, S_WRITE, S_RD_WAIT, S_READ
  } state_t;

  state_t              state;
  logic [MEM_AW-1:0]   addr_q;
  logic [8:0]          len_q;
  logic                wr_n_q;
  logic [8:0]          beat_cnt;
  logic [15:0]         dly_cnt;
  logic                post_ack;
  logic [APP_DW-1:0]   mem [2**MEM_AW];

  // Upper address bits deliberately alias onto the RAM.
  logic addr_hi_unused;
  assign addr_hi_unused = ^app_req_addr[APP_AW-1:MEM_AW];

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      for (int b = 0; b < NB; b++) begin
        if (!app_wr_en_n[b]) mem[addr_q][b*8 +: 8] <= app_wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      wr_n_q          <= 1'b0;
      beat_cnt        <= '0;
      dly_cnt         <= '0;
      post_ack        <= 1'b0;
      app_req_ack     <= 1'b0;
      app_busy_n      <= 1'b1;
      app_wr_next_req <= 1'b0;
      app_rd_valid    <= 1'b0;
      app_rd_data     <= '0;
      app_last_rd     <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      app_req_ack <= 1'b0;
      proto_err   <= 1'b0;
      post_ack    <= (state == S_ACK);
      // A master must drop app_req once it has seen the ack.
      if (post_ack && app_req) proto_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (app_req && !post_ack) begin
            addr_q     <= app_req_addr[MEM_AW-1:0];
            len_q      <= app_req_len;
            wr_n_q     <= app_req_wr_n;
            app_busy_n <= 1'b0;
            dly_cnt    <= '0;
            if (ACK_DLY <= 1) begin
              state       <= S_ACK;
              app_req_ack <= 1'b1;
            end else begin
              state <= S_REQ_WAIT;
            end
          end
        end
        S_REQ_WAIT: begin
          if (!app_req) begin
            state      <= S_IDLE;
            app_busy_n <= 1'b1;
          end else if (dly_cnt == 16'(ACK_TGT)) begin
            state       <= S_ACK;
            app_req_ack <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        S_ACK: begin
          beat_cnt <= '0;
          dly_cnt  <= '0;
          if (len_q == 9'd0) begin
            proto_err  <= 1'b1;
            state      <= S_IDLE;
            app_busy_n <= 1'b1;
          end else if (!wr_n_q) begin
            state           <= S_WRITE;
            app_wr_next_req <= 1'b1;
          end else if (RD_LAT <= 1) begin
            state        <= S_READ;
            app_rd_valid <= 1'b1;
            app_rd_data  <= mem[addr_q];
            app_last_rd  <= (len_q == 9'd1);
            addr_q       <= addr_q + 1'b1;
          end else begin
            state <= S_RD_WAIT;
          end
        end
        S_WRITE: begin
          if (beat_cnt == len_q - 9'd1) begin
            app_wr_next_req <= 1'b0;
            state           <= S_IDLE;
            app_busy_n      <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 9'd1;
            addr_q   <= addr_q + 1'b1;
          end
        end
        S_RD_WAIT: begin
          // First word is fetched here so it appears exactly RD_LAT after the ack.
          if (dly_cnt == 16'(RD_TGT)) begin
            state        <= S_READ;
            app_rd_valid <= 1'b1;
            app_rd_data  <= mem[addr_q];
            app_last_rd  <= (len_q == 9'd1);
            addr_q       <= addr_q + 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        S_READ: begin
          if (beat_cnt == len_q - 9'd1) begin
            app_rd_valid <= 1'b0;
            app_last_rd  <= 1'b0;
            state        <= S_IDLE;
            app_busy_n   <= 1'b1;
          end else begin
            app_rd_data <= mem[addr_q];
            addr_q      <= addr_q + 1'b1;
            beat_cnt    <= beat_cnt + 9'd1;
            app_last_rd <= (beat_cnt + 9'd2 == len_q);
          end
        end
        default: begin
          state      <= S_IDLE;
          app_busy_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_app_responder.sv
// Directed bench for sdrc_app_responder: drivers issue bursts and queue expected
// read beats; a negedge monitor pops and compares every app_rd_valid beat.
module tb_sdrc_app_responder;

  localparam int APP_AW  = 30;
  localparam int APP_DW  = 32;
  localparam int MEM_AW  = 10;
  localparam int ACK_DLY = 2;
  localparam int RD_LAT  = 4;

  logic              clk;
  logic              reset;
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [8:0]        app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic              app_busy_n;
  logic [APP_DW-1:0] app_wr_data;
  logic [3:0]        app_wr_en_n;
  logic              app_wr_next_req;
  logic              app_rd_valid;
  logic [APP_DW-1:0] app_rd_data;
  logic              app_last_rd;
  logic              proto_err;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [APP_DW:0]   exp_q[$];
  logic [APP_DW:0]   mon_exp;
  logic [APP_DW-1:0] wdata[16];
  logic [APP_DW-1:0] rexp[16];
  logic [3:0]        wen;

  sdrc_app_responder #(
    .APP_AW(APP_AW), .APP_DW(APP_DW), .MEM_AW(MEM_AW),
    .ACK_DLY(ACK_DLY), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_busy_n(app_busy_n),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_rd_valid(app_rd_valid),
    .app_rd_data(app_rd_data), .app_last_rd(app_last_rd), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && app_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got data %h last %b, required no beat", app_rd_data, app_last_rd);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({app_last_rd, app_rd_data} !== mon_exp) begin
          errors++;
          $display("FAIL rd_beat: got last %b data %h, required last %b data %h",
                   app_last_rd, app_rd_data, mon_exp[APP_DW], mon_exp[APP_DW-1:0]);
        end
      end
    end
  end

  // drivers
  task automatic request(input logic [APP_AW-1:0] addr, input logic [8:0] len,
                         input logic wr_n, input bit hold, output int lat);
    app_req      = 1'b1;
    app_req_addr = addr;
    app_req_len  = len;
    app_req_wr_n = wr_n;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (app_req_ack) begin
        lat = n;
        break;
      end
    end
    if (!hold) app_req = 1'b0;
  endtask

  task automatic write_burst(input string name, input logic [APP_AW-1:0] addr, input int len);
    int lat, cnt, first, last_i, k;
    request(addr, 9'(len), 1'b0, 1'b0, lat);
    chk({name, "_ack_lat"}, 64'(lat), 64'(ACK_DLY));
    cnt = 0; first = -1; last_i = -1; k = 0;
    for (int n = 1; n <= len + 4; n++) begin
      @(negedge clk);
      app_wr_en_n = 4'hF;
      if (app_wr_next_req) begin
        cnt++;
        if (first < 0) first = n;
        last_i = n;
        app_wr_data = wdata[k % 16];
        app_wr_en_n = wen;
        k++;
      end
    end
    chk({name, "_wr_beats"}, 64'(cnt), 64'(len));
    chk({name, "_wr_first"}, 64'(first), 64'd1);
    chk({name, "_wr_last"}, 64'(last_i), 64'(len));
    chk({name, "_busy_n"}, 64'(app_busy_n), 64'd1);
  endtask

  task automatic read_burst(input string name, input logic [APP_AW-1:0] addr, input int len);
    int lat, first;
    request(addr, 9'(len), 1'b1, 1'b0, lat);
    chk({name, "_ack_lat"}, 64'(lat), 64'(ACK_DLY));
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), rexp[i]});
    first = -1;
    for (int n = 1; n <= len + RD_LAT + 4; n++) begin
      @(negedge clk);
      if (app_rd_valid && first < 0) first = n;
    end
    chk({name, "_rd_lat"}, 64'(first), 64'(RD_LAT));
    chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy_n"}, 64'(app_busy_n), 64'd1);
  endtask

  initial begin
    int lat, cnt, perr, perr_n, ack2, beats;
    reset = 1'b1; app_req = 1'b0; app_req_addr = '0; app_req_len = '0;
    app_req_wr_n = 1'b0; app_wr_data = '0; app_wr_en_n = 4'hF; wen = 4'h0;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, proto_err}), 64'd0);
    chk("rst_busy_n", 64'(app_busy_n), 64'd1);
    chk("rst_rd_data", 64'(app_rd_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2: basic write / read-back
    wdata[0] = 32'hA0A0_A0A0; wdata[1] = 32'hA1A1_A1A1;
    wdata[2] = 32'hA2A2_A2A2; wdata[3] = 32'hA3A3_A3A3;
    wen = 4'h0;
    write_burst("t2_wr", 30'h1_0000, 4);
    for (int i = 0; i < 4; i++) rexp[i] = wdata[i];
    read_burst("t2_rd", 30'h1_0000, 4);

    // 3: byte enables
    wdata[0] = 32'hFFFF_FFFF; wen = 4'h0;
    write_burst("t3_wr_full", 30'h20, 1);
    wdata[0] = 32'h1234_5678; wen = 4'b1010;
    write_burst("t3_wr_part", 30'h20, 1);
    wen = 4'h0;
    rexp[0] = 32'hFF34_FF78;
    read_burst("t3_rd", 30'h20, 1);

    // 4: address wrap and aliasing
    wdata[0] = 32'hB000_0000; wdata[1] = 32'hB000_0001;
    wdata[2] = 32'hB000_0002; wdata[3] = 32'hB000_0003;
    write_burst("t4_wr", 30'h3FE, 4);
    rexp[0] = 32'hB000_0002; rexp[1] = 32'hB000_0003;
    read_burst("t4_rd_lo", 30'h0, 2);
    rexp[0] = 32'hB000_0000; rexp[1] = 32'hB000_0001;
    read_burst("t4_rd_alias", 30'h1000_03FE, 2);

    // 5a: zero length
    request(30'h20, 9'd0, 1'b1, 1'b0, lat);
    chk("t5_len0_ack_lat", 64'(lat), 64'(ACK_DLY));
    @(negedge clk);
    chk("t5_len0_perr", 64'(proto_err), 64'd1);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (app_wr_next_req || app_rd_valid) cnt++;
    end
    chk("t5_len0_beats", 64'(cnt), 64'd0);

    // 5b: request abandoned during REQ_WAIT
    app_req = 1'b1; app_req_addr = 30'h40; app_req_len = 9'd4; app_req_wr_n = 1'b0;
    @(negedge clk);
    app_req = 1'b0;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (app_req_ack || app_wr_next_req) cnt++;
    end
    chk("t5_drop_no_ack", 64'(cnt), 64'd0);
    chk("t5_drop_busy_n", 64'(app_busy_n), 64'd1);

    // 5c: request held after ack
    request(30'h20, 9'd1, 1'b1, 1'b1, lat);
    chk("t5_hold_ack_lat", 64'(lat), 64'(ACK_DLY));
    exp_q.push_back({1'b1, 32'hFF34_FF78});
    perr = 0; perr_n = -1; ack2 = -1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (proto_err) begin
        perr++;
        if (perr_n < 0) perr_n = n;
      end
      if (app_req_ack && ack2 < 0) begin
        ack2 = n;
        app_req = 1'b0;
        exp_q.push_back({1'b1, 32'hFF34_FF78});
      end
    end
    app_req = 1'b0;
    chk("t5_hold_perr_cnt", 64'(perr), 64'd1);
    chk("t5_hold_perr_cyc", 64'(perr_n), 64'd2);
    chk("t5_hold_ack2_cyc", 64'(ack2), 64'(1 + RD_LAT + ACK_DLY));
    chk("t5_hold_beats_left", 64'(exp_q.size()), 64'd0);

    // 6: reset during a read burst
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 32'hC000_0000 + 32'(i);
      rexp[i]  = 32'hC000_0000 + 32'(i);
    end
    write_burst("t6_wr", 30'h100, 8);
    request(30'h100, 9'd8, 1'b1, 1'b0, lat);
    chk("t6_ack_lat", 64'(lat), 64'(ACK_DLY));
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), rexp[i]});
    beats = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (app_rd_valid) beats++;
      if (beats == 2) break;
    end
    chk("t6_beats_before_rst", 64'(beats), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_strobes", 64'({app_rd_valid, app_last_rd, app_wr_next_req, app_req_ack}), 64'd0);
    chk("t6_rst_busy_n", 64'(app_busy_n), 64'd1);
    chk("t6_dropped", 64'(exp_q.size()), 64'd6);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_burst("t6_rd_after", 30'h100, 8);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
